// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing defaults, FSM state encoding and pixel width
package ws2812_pkg;
    localparam int PIX_W       = 24;
    localparam int DEF_T0H     = 20;
    localparam int DEF_T1H     = 40;
    localparam int DEF_T_BIT   = 63;
    localparam int DEF_T_RESET = 2500;

    typedef enum logic [1:0] {IDLE, PREFETCH, SEND, TRESET} state_t;

    // Scales each colour byte by (c*(b+1))>>8; b=255 passes through, b=0 gives black
    function automatic logic [PIX_W-1:0] scale_pix(input logic [PIX_W-1:0] p, input logic [7:0] b);
        logic [PIX_W-1:0] r;
        logic [15:0] m;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            m = 16'(p[8*i +: 8]) * (16'(b) + 16'd1);
            r[8*i +: 8] = m[15:8];
        end
        return r;
    endfunction
endpackage

// File: rtl/ws2812_multi_driver_if.sv
// ws2812_multi_driver_if: valid/ready pixel stream from the pattern generator to the strip driver
interface ws2812_multi_driver_if;
    import ws2812_pkg::*;
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/ws2812_channel_serializer.sv
// ws2812_channel_serializer: one strip's 24-bit shift register and bit waveform compare
module ws2812_channel_serializer import ws2812_pkg::*; #(
    parameter int T0H = DEF_T0H,
    parameter int T1H = DEF_T1H,
    parameter int TW  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_data,
    input  logic [TW-1:0]    i_timer,
    output logic             o_dout
);
    localparam logic [TW-1:0] H0 = TW'(T0H);
    localparam logic [TW-1:0] H1 = TW'(T1H);

    logic [PIX_W-1:0] r_sr;
    logic             r_dout;

    // MSB is the bit on the line; the line is high for the first T0H/T1H cycles of each bit
    always_ff @(posedge clk)
        if (reset) begin
            r_sr   <= '0;
            r_dout <= 1'b0;
        end else begin
            r_sr   <= i_load ? i_data : i_shift ? {r_sr[PIX_W-2:0], 1'b0} : r_sr;
            r_dout <= i_en && (i_timer < (r_sr[PIX_W-1] ? H1 : H0));
        end

    assign o_dout = r_dout;
endmodule

// File: rtl/ws2812_multi_driver.sv
// ws2812_multi_driver: N_CH bit-aligned WS2812 strips fed from a pixel stream with a per-channel
// shadow prefetch bank. Optional macro WS2812_BRIGHTNESS_EN adds i_brightness pixel scaling.
module ws2812_multi_driver import ws2812_pkg::*; #(
    parameter int N_CH      = 4,
    parameter int LED_COUNT = 8,
    parameter int T0H       = DEF_T0H,
    parameter int T1H       = DEF_T1H,
    parameter int T_BIT     = DEF_T_BIT,
    parameter int T_RESET   = DEF_T_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    ws2812_multi_driver_if.slave pix,
    output logic [N_CH-1:0]   o_dout,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_underrun
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]        i_brightness
`endif
);
    localparam int TW = $clog2((T_BIT > T_RESET) ? T_BIT : T_RESET);
    localparam int LW = $clog2(LED_COUNT + 2);
    localparam int SW = $clog2(N_CH + 1);

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [4:0]       r_bit;
    logic [LW-1:0]    r_led;
    logic [LW-1:0]    r_fetch;
    logic [SW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_und;
    logic [PIX_W-1:0] r_shadow [N_CH];

    logic             w_full;
    logic             w_last_t;
    logic             w_bnd;
    logic             w_end;
    logic             w_load;
    logic             w_shift;
    logic             w_ready;
    logic             w_fire;
    logic [LW-1:0]    w_next_fetch;
    logic [SW-1:0]    w_slot;
    logic [PIX_W-1:0] w_pix;

    assign w_full       = r_cnt == SW'(N_CH);
    assign w_last_t     = r_timer == TW'(T_BIT - 1);
    assign w_bnd        = r_state == SEND && w_last_t && r_bit == 5'(PIX_W - 1);
    assign w_end        = w_bnd && r_led == LW'(LED_COUNT - 1);
    assign w_load       = (r_state == PREFETCH && w_full) || (w_bnd && !w_end);
    assign w_shift      = r_state == SEND && w_last_t && !w_bnd;
    // A pixel accepted on an LED boundary belongs to the LED after the one being loaded
    assign w_next_fetch = r_fetch + LW'(w_bnd);
    assign w_ready      = (r_state == PREFETCH || r_state == SEND) && !w_full && w_next_fetch < LW'(LED_COUNT);
    assign w_fire       = pix.pix_valid && w_ready;
    assign w_slot       = w_load ? '0 : r_cnt;
`ifdef WS2812_BRIGHTNESS_EN
    assign w_pix        = scale_pix(pix.pix_data, i_brightness);
`else
    assign w_pix        = pix.pix_data;
`endif

    // Frame sequencing: shared bit timer, bit/LED counters, fetch pointer and status flags
    always_ff @(posedge clk)
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_led   <= '0;
            r_fetch <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_load ? SW'(w_fire) : w_fire ? r_cnt + SW'(1) : r_cnt;
            case (r_state)
                IDLE:
                    if (i_start) begin
                        r_state <= PREFETCH;
                        r_busy  <= 1'b1;
                        r_und   <= 1'b0;
                        r_timer <= '0;
                        r_bit   <= '0;
                        r_led   <= '0;
                        r_fetch <= '0;
                    end
                PREFETCH:
                    if (w_full) begin
                        r_state <= SEND;
                        r_fetch <= LW'(1);
                    end
                SEND: begin
                    r_timer <= w_last_t ? '0 : r_timer + TW'(1);
                    if (w_last_t) r_bit <= w_bnd ? '0 : r_bit + 5'd1;
                    if (w_end) r_state <= TRESET;
                    else if (w_bnd) begin
                        r_led   <= r_led + LW'(1);
                        r_fetch <= r_fetch + LW'(1);
                        r_und   <= r_und | !w_full;
                    end
                end
                TRESET:
                    if (r_timer == TW'(T_RESET - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_timer <= '0;
                    end else r_timer <= r_timer + TW'(1);
                default: r_state <= IDLE;
            endcase
        end

    // Shadow bank: accepted pixels land in the next free slot of the LED being fetched
    always_ff @(posedge clk)
        for (int c = 0; c < N_CH; c++)
            if (w_fire && w_slot == SW'(c)) r_shadow[c] <= w_pix;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ws2812_channel_serializer #(.T0H(T0H), .T1H(T1H), .TW(TW)) u_ser (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_en    (r_state == SEND),
            .i_data  ((SW'(g) < r_cnt) ? r_shadow[g] : '0),
            .i_timer (r_timer),
            .o_dout  (o_dout[g])
        );
    end

    assign pix.pix_ready = w_ready;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_done;
    assign o_underrun    = r_und;
endmodule
